// File: rtl/add_pkg.sv
`default_nettype none
// ============================================================================
// Module      : add_pkg
// Description : Shared defaults and helpers for the pipelined RCA adder family.
// Revision    : 1.0 - initial release
// ============================================================================
package add_pkg;

    localparam int ADD_DEF_WIDTH = 32;
    localparam int ADD_DEF_SEG   = 8;

    // Signed overflow: carry into the MSB disagrees with carry out of it.
    function automatic logic ovf_f(input logic c_msb_in, input logic c_msb_out);
        return c_msb_in ^ c_msb_out;
    endfunction

endpackage
`default_nettype wire

// File: rtl/add_rca_seg.sv
`default_nettype none
// ============================================================================
// Module      : add_rca_seg
// Description : Combinational SEG_WIDTH-bit ripple of full adders.
// Revision    : 1.0 - initial release
// ============================================================================
module add_rca_seg
    import add_pkg::*;
#(
    parameter int SEG_WIDTH = ADD_DEF_SEG
) (
    input  logic [SEG_WIDTH-1:0] a,
    input  logic [SEG_WIDTH-1:0] b,
    input  logic                 cin,
    output logic [SEG_WIDTH-1:0] sum,
    output logic                 cout,
    output logic                 c_msb
);

    always_comb begin : ripple
        logic [SEG_WIDTH:0] w_carry;
        w_carry    = '0;
        sum        = '0;
        w_carry[0] = cin;
        for (int i = 0; i < SEG_WIDTH; i++) begin
            sum[i]       = a[i] ^ b[i] ^ w_carry[i];
            w_carry[i+1] = (a[i] & b[i]) | (a[i] & w_carry[i]) | (b[i] & w_carry[i]);
        end
        cout  = w_carry[SEG_WIDTH];
        c_msb = w_carry[SEG_WIDTH-1];
    end

endmodule
`default_nettype wire

// File: rtl/add_rca_pipe.sv
`default_nettype none
// ============================================================================
// Module      : add_rca_pipe
// Description : Pipelined ripple-carry adder/subtractor, one segment per stage,
//               with per-stage valid bits and valid/ready flow control.
// Revision    : 1.0 - initial release
// ============================================================================
module add_rca_pipe
    import add_pkg::*;
#(
    parameter int WIDTH     = ADD_DEF_WIDTH,
    parameter int SEG_WIDTH = ADD_DEF_SEG
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int STAGES = WIDTH / SEG_WIDTH;

    if (STAGES < 1 || (WIDTH % SEG_WIDTH) != 0) begin : g_param_check
        $error("add_rca_pipe: WIDTH must be a non-zero multiple of SEG_WIDTH");
    end

    logic [STAGES-1:0] w_v;
    logic [STAGES-1:0] w_rdy;

    // A stage may load when it is empty or its successor is moving.
    always_comb begin : rdy_chain
        logic w_next_rdy;
        w_rdy      = '0;
        w_next_rdy = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_rdy[k]   = ~w_v[k] | w_next_rdy;
            w_next_rdy = w_rdy[k];
        end
    end

    assign in_ready = w_rdy[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int W_IN = WIDTH - k * SEG_WIDTH;   // operand bits still to add
        localparam int W_LO = (k + 1) * SEG_WIDTH;     // result bits known after this stage

        logic [W_IN-1:0]      w_a_in;
        logic [W_IN-1:0]      w_b_in;
        logic                 w_c_in;
        logic                 w_v_in;
        logic [W_LO-1:0]      w_sum_nxt;
        logic [SEG_WIDTH-1:0] w_seg_sum;
        logic                 w_seg_cout;
        logic                 w_ld;

        logic                 r_v;
        logic                 r_carry;
        logic [W_LO-1:0]      r_sum;

        if (k == 0) begin : g_head
            assign w_a_in    = a;
            assign w_b_in    = b ^ {WIDTH{sub}};
            assign w_c_in    = cin ^ sub;
            assign w_v_in    = in_valid;
            assign w_sum_nxt = w_seg_sum;
        end else begin : g_tail
            assign w_a_in    = g_stage[k-1].g_skew.r_a_hi;
            assign w_b_in    = g_stage[k-1].g_skew.r_b_hi;
            assign w_c_in    = g_stage[k-1].r_carry;
            assign w_v_in    = g_stage[k-1].r_v;
            assign w_sum_nxt = {w_seg_sum, g_stage[k-1].r_sum};
        end

        assign w_ld   = w_rdy[k] & w_v_in;
        assign w_v[k] = r_v;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v     <= 1'b0;
                r_carry <= 1'b0;
                r_sum   <= '0;
            end else if (w_rdy[k]) begin
                r_v <= w_v_in;
                if (w_v_in) begin
                    r_carry <= w_seg_cout;
                    r_sum   <= w_sum_nxt;
                end
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [W_IN-SEG_WIDTH-1:0] r_a_hi;
            logic [W_IN-SEG_WIDTH-1:0] r_b_hi;
            logic                      w_c_msb_unused;

            add_rca_seg #(
                .SEG_WIDTH (SEG_WIDTH)
            ) u_seg (
                .a     (w_a_in[SEG_WIDTH-1:0]),
                .b     (w_b_in[SEG_WIDTH-1:0]),
                .cin   (w_c_in),
                .sum   (w_seg_sum),
                .cout  (w_seg_cout),
                .c_msb (w_c_msb_unused)
            );

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a_hi <= '0;
                    r_b_hi <= '0;
                end else if (w_ld) begin
                    r_a_hi <= w_a_in[W_IN-1:SEG_WIDTH];
                    r_b_hi <= w_b_in[W_IN-1:SEG_WIDTH];
                end
            end
        end else begin : g_last
            logic w_c_msb;
            logic r_ovf;

            add_rca_seg #(
                .SEG_WIDTH (SEG_WIDTH)
            ) u_seg (
                .a     (w_a_in[SEG_WIDTH-1:0]),
                .b     (w_b_in[SEG_WIDTH-1:0]),
                .cin   (w_c_in),
                .sum   (w_seg_sum),
                .cout  (w_seg_cout),
                .c_msb (w_c_msb)
            );

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ovf <= 1'b0;
                end else if (w_ld) begin
                    r_ovf <= ovf_f(w_c_msb, w_seg_cout);
                end
            end
        end
    end

    // Outputs are taken straight from the last stage registers.
    assign out_valid = g_stage[STAGES-1].r_v;
    assign sum       = g_stage[STAGES-1].r_sum;
    assign c_out     = g_stage[STAGES-1].r_carry;
    assign ovf       = g_stage[STAGES-1].g_last.r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_add_rca_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_add_rca_pipe
// Description : Self-checking bench for add_rca_pipe (16-bit, 4-bit segments).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_add_rca_pipe;

    localparam int WIDTH     = 16;
    localparam int SEG_WIDTH = 4;
    localparam int STAGES    = WIDTH / SEG_WIDTH;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              cin;
    logic              sub;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  sum;
    logic              c_out;
    logic              ovf;

    always #5 clk = ~clk;

    add_rca_pipe #(
        .WIDTH     (WIDTH),
        .SEG_WIDTH (SEG_WIDTH)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             v;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   run_len  = 0;
    int   max_run  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    // Reference: plain two's-complement arithmetic on the effective operands.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic ci, input logic sb);
        logic [WIDTH-1:0] yy;
        logic [WIDTH:0]   t;
        exp_t             e;
        yy  = sb ? ~y : y;
        t   = {1'b0, x} + {1'b0, yy} + (WIDTH+1)'(ci ^ sb);
        e.s = t[WIDTH-1:0];
        e.c = t[WIDTH];
        e.v = (x[WIDTH-1] == yy[WIDTH-1]) && (t[WIDTH-1] != x[WIDTH-1]);
        return e;
    endfunction

    // One clock: observe handshakes at the settled negedge, then advance.
    task automatic cycle(output bit acc);
        exp_t e;
        #1;
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check_eq("spurious_out", 32'(sum), 32'hDEAD);
            end else begin
                e = q.pop_front();
                check_eq("sum",   32'(sum),   32'(e.s));
                check_eq("c_out", 32'(c_out), 32'(e.c));
                check_eq("ovf",   32'(ovf),   32'(e.v));
            end
        end
        if (acc) q.push_back(cur);
        run_len = out_valid ? run_len + 1 : 0;
        if (run_len > max_run) max_run = run_len;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic present(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                           input logic ci, input logic sb, input exp_t e);
        a        = x;
        b        = y;
        cin      = ci;
        sub      = sb;
        cur      = e;
        in_valid = 1'b1;
    endtask

    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic ci, input logic sb, input exp_t e);
        bit acc;
        int n;
        present(x, y, ci, sb, e);
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 100) begin
            cycle(acc);
            n++;
        end
        if (!acc) check_eq("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        bit acc;
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (q.size() > 0 && n < max_cycles) begin
            cycle(acc);
            n++;
        end
        if (q.size() != 0) check_eq("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    // Send one item on an empty pipe and verify out_valid appears exactly STAGES cycles later.
    task automatic send_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                            input logic ci, input logic sb, input exp_t e, input string tag);
        bit acc;
        out_ready = 1'b1;
        send(x, y, ci, sb, e);
        for (int n = 1; n <= STAGES + 1; n++) begin
            check_eq(tag, 32'(out_valid), 32'(n == STAGES));
            cycle(acc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit               acc;
        bit               pend;
        int               acc_n;
        int               sent;
        int               n;
        exp_t             held;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic             ci;
        logic             sb;

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        #1 rst_n  = 1'b0;
        #3;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready",  32'(in_ready),  32'd1);
        check_eq("rst_sum",       32'(sum),       32'd0);
        check_eq("rst_c_out",     32'(c_out),     32'd0);
        check_eq("rst_ovf",       32'(ovf),       32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors with hand-derived expectations.
        send_lat(16'hFFFF, 16'h0001, 1'b0, 1'b0, '{s: 16'h0000, c: 1'b1, v: 1'b0}, "lat_ffff");
        send_lat(16'h7FFF, 16'h0001, 1'b0, 1'b0, '{s: 16'h8000, c: 1'b0, v: 1'b1}, "lat_7fff");
        send_lat(16'h1234, 16'h4321, 1'b1, 1'b0, '{s: 16'h5556, c: 1'b0, v: 1'b0}, "lat_1234");
        send_lat(16'h0005, 16'h0007, 1'b0, 1'b1, '{s: 16'hFFFE, c: 1'b0, v: 1'b0}, "lat_sub5");
        send_lat(16'h8000, 16'h0001, 1'b0, 1'b1, '{s: 16'h7FFF, c: 1'b1, v: 1'b1}, "lat_sub8");

        // Back-to-back stream.
        run_len = 0;
        max_run = 0;
        for (int i = 0; i < 8; i++) begin
            x = 16'(i);
            y = 16'(i * 16);
            send(x, y, 1'b0, 1'b0, model(x, y, 1'b0, 1'b0));
        end
        drain(20);
        check_eq("b2b_run", 32'(max_run), 32'd8);

        // Backpressure: five offered with the consumer stalled.
        out_ready = 1'b0;
        acc_n     = 0;
        for (int c = 0; c < 12; c++) begin
            if (acc_n < 5) begin
                x = 16'(acc_n * 256 + 3);
                y = 16'(acc_n);
                present(x, y, 1'b0, 1'b0, model(x, y, 1'b0, 1'b0));
            end
            cycle(acc);
            if (acc) acc_n++;
        end
        check_eq("stall_accepts", 32'(acc_n),     32'd4);
        check_eq("stall_in_rdy",  32'(in_ready),  32'd0);
        check_eq("stall_valid",   32'(out_valid), 32'd1);
        held = q[0];
        for (int c = 0; c < 3; c++) begin
            check_eq("hold_sum", 32'(sum), 32'(held.s));
            cycle(acc);
            if (acc) acc_n++;
        end
        out_ready = 1'b1;
        #1;
        check_eq("full_accept_rdy", 32'(in_ready), 32'd1);
        n = 0;
        while (acc_n < 5 && n < 50) begin
            cycle(acc);
            if (acc) acc_n++;
            n++;
        end
        in_valid = 1'b0;
        drain(20);
        check_eq("stall_total", 32'(acc_n), 32'd5);

        // Asynchronous reset with results in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            x = 16'(16'h1111 * (i + 1));
            y = 16'h2222;
            send(x, y, 1'b0, 1'b0, model(x, y, 1'b0, 1'b0));
        end
        n = 0;
        while (!out_valid && n < 10) begin
            cycle(acc);
            n++;
        end
        check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", 32'(out_valid), 32'd0);
        check_eq("arst_sum",       32'(sum),       32'd0);
        check_eq("arst_in_ready",  32'(in_ready),  32'd1);
        q.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            check_eq("post_rst_idle", 32'(out_valid), 32'd0);
            cycle(acc);
        end
        send_lat(16'h00F0, 16'h0F0F, 1'b1, 1'b0, '{s: 16'h1000, c: 1'b0, v: 1'b0}, "lat_post_rst");

        // Randomized traffic with random backpressure.
        pend = 1'b0;
        sent = 0;
        for (int it = 0; it < 400; it++) begin
            if (!pend && sent < 250 && $urandom_range(3) != 0) begin
                x  = 16'($urandom);
                y  = 16'($urandom);
                ci = 1'($urandom);
                sb = 1'($urandom);
                present(x, y, ci, sb, model(x, y, ci, sb));
                pend = 1'b1;
            end else if (!pend) begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(3) != 0);
            cycle(acc);
            if (acc) begin
                pend     = 1'b0;
                sent++;
                in_valid = 1'b0;
            end
        end
        if (pend) begin
            in_valid  = 1'b1;
            out_ready = 1'b1;
            n = 0;
            acc = 1'b0;
            while (!acc && n < 50) begin
                cycle(acc);
                n++;
            end
            if (!acc) check_eq("rand_tail_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end
        drain(100);
        check_eq("sb_empty", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
